// File: rtl/ball_mover_if.sv
// Control/position bundle between the game logic and the ball mover.
interface ball_mover_if;
  logic       tick;
  logic       serve_req;
  logic [9:0] plat_x;
  logic       brick_hit;
  logic       game_over;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       miss_pulse;
  logic       serving;

  modport master (
    output tick, serve_req, plat_x, brick_hit, game_over,
    input  ball_x, ball_y, dir_x, dir_y, miss_pulse, serving
  );

  modport slave (
    input  tick, serve_req, plat_x, brick_hit, game_over,
    output ball_x, ball_y, dir_x, dir_y, miss_pulse, serving
  );
endinterface

// File: rtl/ball_mover.sv
// Ball position generator: serve parking, launch delay, per-tick motion with
// wall/ceiling/platform bounces, brick flips and a bottom-exit miss pulse.
module ball_mover #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PLAT_Y      = 110,
  parameter int PLAT_W      = 16,
  parameter int SERVE_Y     = 100,
  parameter int SERVE_DELAY = 60
) (
  input  logic         clk,
  input  logic         reset,
  ball_mover_if.slave  bus
);

  localparam int SERVE_X = SCREEN_W / 2;

  typedef enum logic [2:0] {
    S_SERVE, S_DELAY, S_MOVE, S_OUT, S_HALT
  } state_t;

  state_t     state, next_state;
  logic [9:0] x_q, y_q;
  logic       dx_q, dy_q;
  logic [9:0] cnt_q;
  logic       pend_q;

  logic [10:0] track_sum;
  logic [9:0]  track_x;
  logic        dy_eff;
  logic        plat_hit;
  logic [9:0]  nx, ny;
  logic        ndx, ndy;
  logic        hit_bottom;

  // Serve position follows the platform centre, clamped to the right edge.
  always_comb begin
    track_sum = {1'b0, bus.plat_x} + 11'(PLAT_W / 2);
    track_x   = (track_sum > 11'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : track_sum[9:0];
  end

  always_comb begin
    dy_eff     = dy_q ^ (pend_q | bus.brick_hit);
    plat_hit   = ({1'b0, x_q} >= {1'b0, bus.plat_x}) &&
                 ({1'b0, x_q} <= ({1'b0, bus.plat_x} + 11'(PLAT_W - 1)));
    nx         = x_q;
    ndx        = dx_q;
    ny         = y_q;
    ndy        = dy_eff;
    hit_bottom = 1'b0;

    if (dx_q && (x_q == 10'(SCREEN_W - 1))) begin
      ndx = 1'b0;
    end else if (!dx_q && (x_q == 10'd0)) begin
      ndx = 1'b1;
    end else if (dx_q) begin
      nx = x_q + 10'd1;
    end else begin
      nx = x_q - 10'd1;
    end

    if (!dy_eff && (y_q == 10'd0)) begin
      ndy = 1'b1;
    end else if (dy_eff && (y_q == 10'(PLAT_Y - 1)) && plat_hit) begin
      ndy = 1'b0;
    end else if (dy_eff && (y_q == 10'(SCREEN_H - 1))) begin
      hit_bottom = 1'b1;
    end else if (dy_eff) begin
      ny = y_q + 10'd1;
    end else begin
      ny = y_q - 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_SERVE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.game_over) begin
      next_state = S_HALT;
    end else begin
      case (state)
        S_SERVE: if (bus.serve_req) next_state = S_DELAY;
        S_DELAY: if (bus.tick && (cnt_q == 10'd1)) next_state = S_MOVE;
        S_MOVE:  if (bus.tick && hit_bottom) next_state = S_OUT;
        S_OUT:   next_state = S_SERVE;
        default: next_state = S_HALT;
      endcase
    end
  end

  always_comb begin
    bus.serving    = (state == S_SERVE) || (state == S_DELAY);
    bus.miss_pulse = (state == S_OUT);
    bus.ball_x     = x_q;
    bus.ball_y     = y_q;
    bus.dir_x      = dx_q;
    bus.dir_y      = dy_q;
  end

  // game_over freezes every register; HALT itself holds everything too.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= 10'(SERVE_X);
      y_q    <= 10'(SERVE_Y);
      dx_q   <= 1'b1;
      dy_q   <= 1'b0;
      cnt_q  <= 10'd0;
      pend_q <= 1'b0;
    end else if (!bus.game_over) begin
      case (state)
        S_SERVE, S_DELAY, S_OUT: begin
          x_q    <= track_x;
          y_q    <= 10'(SERVE_Y);
          dx_q   <= 1'b1;
          dy_q   <= 1'b0;
          pend_q <= 1'b0;
          if (state == S_SERVE && bus.serve_req) cnt_q <= 10'(SERVE_DELAY);
          else if (state == S_DELAY && bus.tick)  cnt_q <= cnt_q - 10'd1;
        end
        S_MOVE: begin
          if (bus.tick) begin
            x_q    <= nx;
            y_q    <= ny;
            dx_q   <= ndx;
            dy_q   <= ndy;
            pend_q <= 1'b0;
          end else if (bus.brick_hit) begin
            pend_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover with a 3-tick serve delay.
module tb_ball_mover;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_mover_if bus();
  ball_mover #(.SERVE_DELAY(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick(input logic bh);
    bus.brick_hit = bh; bus.tick = 1'b1; cyc(1);
    bus.brick_hit = 1'b0; bus.tick = 1'b0; cyc(3);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic serve(input logic [9:0] px);
    bus.plat_x = px; bus.serve_req = 1'b1; cyc(1);
    bus.serve_req = 1'b0; cyc(1);
    run_ticks(3);
  endtask

  task automatic pulse_reset;
    reset = 1'b1; cyc(1);
    checks++; if (bus.serving !== 1'b1 || bus.ball_y !== 10'd100) begin errors++; $display("FAIL abort_reset: serving=%0b y=%0d expected 1/100", bus.serving, bus.ball_y); end
    reset = 1'b0;
  endtask

  task automatic test_reset;
    bus.plat_x = 10'd0; cyc(3);
    checks++; if (bus.ball_x !== 10'd80 || bus.ball_y !== 10'd100) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (80,100)", bus.ball_x, bus.ball_y); end
    checks++; if (bus.dir_x !== 1'b1 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0b%0b expected 10", bus.dir_x, bus.dir_y); end
    checks++; if (bus.miss_pulse !== 1'b0 || bus.serving !== 1'b1) begin errors++; $display("FAIL reset_flags: miss=%0b serving=%0b expected 0/1", bus.miss_pulse, bus.serving); end
    reset = 1'b0; cyc(1);
    checks++; if (bus.ball_x !== 10'd8) begin errors++; $display("FAIL track_low: got %0d expected 8", bus.ball_x); end
    bus.plat_x = 10'd200; cyc(1);
    checks++; if (bus.ball_x !== 10'd159) begin errors++; $display("FAIL track_clamp: got %0d expected 159", bus.ball_x); end
  endtask

  task automatic test_serve_launch;
    bus.plat_x = 10'd72; cyc(1);
    bus.serve_req = 1'b1; cyc(1); bus.serve_req = 1'b0; cyc(1);
    checks++; if (bus.serving !== 1'b1 || bus.ball_x !== 10'd80) begin errors++; $display("FAIL delay_entry: serving=%0b x=%0d expected 1/80", bus.serving, bus.ball_x); end
    do_tick(1'b0);
    do_tick(1'b0);
    checks++; if (bus.serving !== 1'b1) begin errors++; $display("FAIL delay_tick2: serving=%0b expected 1", bus.serving); end
    do_tick(1'b0);
    checks++; if (bus.serving !== 1'b0 || bus.ball_y !== 10'd100) begin errors++; $display("FAIL delay_done: serving=%0b y=%0d expected 0/100", bus.serving, bus.ball_y); end
    do_tick(1'b0);
    checks++; if (bus.ball_x !== 10'd81 || bus.ball_y !== 10'd99) begin errors++; $display("FAIL first_move: got (%0d,%0d) expected (81,99)", bus.ball_x, bus.ball_y); end
  endtask

  task automatic test_brick_double;
    run_ticks(49);
    checks++; if (bus.ball_x !== 10'd130 || bus.ball_y !== 10'd50 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL pre_brick: got (%0d,%0d) dy=%0b expected (130,50) dy=0", bus.ball_x, bus.ball_y, bus.dir_y); end
    bus.brick_hit = 1'b1; cyc(1); bus.brick_hit = 1'b0; cyc(1);
    bus.brick_hit = 1'b1; cyc(1); bus.brick_hit = 1'b0; cyc(1);
    do_tick(1'b0);
    checks++; if (bus.dir_y !== 1'b1 || bus.ball_y !== 10'd51 || bus.ball_x !== 10'd131) begin errors++; $display("FAIL brick_single_flip: got (%0d,%0d) dy=%0b expected (131,51) dy=1", bus.ball_x, bus.ball_y, bus.dir_y); end
    do_tick(1'b1);
    checks++; if (bus.dir_y !== 1'b0 || bus.ball_y !== 10'd50) begin errors++; $display("FAIL brick_same_tick: y=%0d dy=%0b expected 50 dy=0", bus.ball_y, bus.dir_y); end
  endtask

  task automatic test_wall_bounce;
    run_ticks(27);
    checks++; if (bus.ball_x !== 10'd159 || bus.dir_x !== 1'b1 || bus.ball_y !== 10'd23) begin errors++; $display("FAIL at_wall: got (%0d,%0d) dx=%0b expected (159,23) dx=1", bus.ball_x, bus.ball_y, bus.dir_x); end
    do_tick(1'b0);
    checks++; if (bus.ball_x !== 10'd159 || bus.dir_x !== 1'b0 || bus.ball_y !== 10'd22) begin errors++; $display("FAIL wall_flip: got (%0d,%0d) dx=%0b expected (159,22) dx=0", bus.ball_x, bus.ball_y, bus.dir_x); end
    do_tick(1'b0);
    checks++; if (bus.ball_x !== 10'd158 || bus.ball_y !== 10'd21) begin errors++; $display("FAIL wall_leave: got (%0d,%0d) expected (158,21)", bus.ball_x, bus.ball_y); end
  endtask

  task automatic launch_down(input logic [9:0] px_flight);
    pulse_reset();
    bus.plat_x = 10'd63; cyc(1);
    serve(10'd63);
    bus.plat_x = px_flight;
    do_tick(1'b1);
    checks++; if (bus.dir_y !== 1'b1 || bus.ball_y !== 10'd101 || bus.ball_x !== 10'd72) begin errors++; $display("FAIL launch_down: got (%0d,%0d) dy=%0b expected (72,101) dy=1", bus.ball_x, bus.ball_y, bus.dir_y); end
    run_ticks(8);
    checks++; if (bus.ball_x !== 10'd80 || bus.ball_y !== 10'd109) begin errors++; $display("FAIL above_plat: got (%0d,%0d) expected (80,109)", bus.ball_x, bus.ball_y); end
  endtask

  task automatic test_platform_hit;
    launch_down(10'd72);
    do_tick(1'b0);
    checks++; if (bus.dir_y !== 1'b0 || bus.ball_y !== 10'd109 || bus.ball_x !== 10'd81) begin errors++; $display("FAIL plat_bounce: got (%0d,%0d) dy=%0b expected (81,109) dy=0", bus.ball_x, bus.ball_y, bus.dir_y); end
  endtask

  task automatic test_platform_miss;
    launch_down(10'd100);
    do_tick(1'b0);
    checks++; if (bus.dir_y !== 1'b1 || bus.ball_y !== 10'd110) begin errors++; $display("FAIL plat_miss: y=%0d dy=%0b expected 110 dy=1", bus.ball_y, bus.dir_y); end
    run_ticks(9);
    checks++; if (bus.ball_y !== 10'd119 || bus.ball_x !== 10'd90 || bus.miss_pulse !== 1'b0) begin errors++; $display("FAIL bottom_row: got (%0d,%0d) miss=%0b expected (90,119) miss=0", bus.ball_x, bus.ball_y, bus.miss_pulse); end
    bus.tick = 1'b1; cyc(1); bus.tick = 1'b0;
    checks++; if (bus.miss_pulse !== 1'b1 || bus.serving !== 1'b0 || bus.ball_x !== 10'd91 || bus.ball_y !== 10'd119) begin errors++; $display("FAIL out_state: miss=%0b serving=%0b (%0d,%0d) expected 1/0 (91,119)", bus.miss_pulse, bus.serving, bus.ball_x, bus.ball_y); end
    cyc(1);
    checks++; if (bus.miss_pulse !== 1'b0 || bus.serving !== 1'b1 || bus.ball_y !== 10'd100 || bus.ball_x !== 10'd108) begin errors++; $display("FAIL reserve: miss=%0b serving=%0b (%0d,%0d) expected 0/1 (108,100)", bus.miss_pulse, bus.serving, bus.ball_x, bus.ball_y); end
  endtask

  task automatic test_game_over;
    int miss_seen;
    miss_seen = 0;
    pulse_reset();
    bus.plat_x = 10'd72; cyc(1);
    serve(10'd72);
    run_ticks(40);
    checks++; if (bus.ball_x !== 10'd120 || bus.ball_y !== 10'd60) begin errors++; $display("FAIL pre_halt: got (%0d,%0d) expected (120,60)", bus.ball_x, bus.ball_y); end
    bus.game_over = 1'b1; cyc(1);
    for (int i = 0; i < 40; i++) begin
      bus.tick = (i % 4 == 0);
      cyc(1);
      if (bus.miss_pulse === 1'b1) miss_seen++;
    end
    bus.tick = 1'b0;
    checks++; if (bus.ball_x !== 10'd120 || bus.ball_y !== 10'd60 || miss_seen != 0) begin errors++; $display("FAIL halt_freeze: got (%0d,%0d) misses=%0d expected (120,60) 0", bus.ball_x, bus.ball_y, miss_seen); end
    bus.game_over = 1'b0;
    bus.serve_req = 1'b1; do_tick(1'b0); bus.serve_req = 1'b0;
    checks++; if (bus.ball_x !== 10'd120 || bus.ball_y !== 10'd60 || bus.serving !== 1'b0) begin errors++; $display("FAIL halt_sticky: got (%0d,%0d) serving=%0b expected (120,60) 0", bus.ball_x, bus.ball_y, bus.serving); end
    reset = 1'b1; cyc(1);
    checks++; if (bus.ball_x !== 10'd80 || bus.ball_y !== 10'd100 || bus.serving !== 1'b1) begin errors++; $display("FAIL halt_reset: got (%0d,%0d) serving=%0b expected (80,100) 1", bus.ball_x, bus.ball_y, bus.serving); end
    reset = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.serve_req = 1'b0; bus.plat_x = 10'd0;
    bus.brick_hit = 1'b0; bus.game_over = 1'b0;
    test_reset();
    test_serve_launch();
    test_brick_double();
    test_wall_bounce();
    test_platform_hit();
    test_platform_miss();
    test_game_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
